// File: rtl/rr_request_source_pkg.sv
// Shared constants, types and helpers for the round-robin arbiter and
// its requester-side agent.
package rr_arb_pkg;

  localparam int N_REQ     = 16;
  localparam int REQ_IDX_W = $clog2(N_REQ);
  localparam int CNT_W     = 8;
  localparam int WAIT_W    = 16;

  typedef logic [N_REQ-1:0] req_vec_t;

  // True when at most one bit of the vector is set.
  function automatic logic onehot0(input req_vec_t vec);
    return (vec & (vec - req_vec_t'(1))) == req_vec_t'(0);
  endfunction

endpackage

// File: rtl/rr_req_slot.sv
// One requester slot: saturating pending-job counter plus a wait-cycle
// counter that tracks how long the current request has gone ungranted.
module rr_req_slot
  import rr_arb_pkg::*;
#(
  parameter int CNT_W  = rr_arb_pkg::CNT_W,
  parameter int WAIT_W = rr_arb_pkg::WAIT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              trigger,
  input  logic              load_en,
  input  logic [CNT_W-1:0]  load_count,
  input  logic              grant_bit,
  input  logic              accept,
  output logic              request,
  output logic [CNT_W-1:0]  pend_nxt,
  output logic [WAIT_W-1:0] wait_nxt
);

  logic [CNT_W-1:0]  pend_r;
  logic [WAIT_W-1:0] wait_r;
  logic [CNT_W:0]    add_s;
  logic [CNT_W:0]    sum_s;

  assign request = trigger & (pend_r != {CNT_W{1'b0}});

  // Next pend: add load and retire accepted job in one step, then saturate;
  // next wait: count ungranted requested cycles, clear otherwise.
  always_comb begin
    if (load_en) begin
      add_s = {1'b0, load_count};
    end else begin
      add_s = {(CNT_W+1){1'b0}};
    end
    // accept implies pend_r >= 1, so the subtraction cannot underflow.
    sum_s = {1'b0, pend_r} + add_s - {{CNT_W{1'b0}}, accept};
    if (sum_s > {1'b0, {CNT_W{1'b1}}}) begin
      pend_nxt = {CNT_W{1'b1}};
    end else begin
      pend_nxt = sum_s[CNT_W-1:0];
    end

    if (!request) begin
      wait_nxt = {WAIT_W{1'b0}};
    end else if (grant_bit) begin
      wait_nxt = {WAIT_W{1'b0}};
    end else if (wait_r == {WAIT_W{1'b1}}) begin
      wait_nxt = wait_r;
    end else begin
      wait_nxt = wait_r + WAIT_W'(1);
    end
  end

  // Slot state registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_r <= {CNT_W{1'b0}};
      wait_r <= {WAIT_W{1'b0}};
    end else begin
      pend_r <= pend_nxt;
      wait_r <= wait_nxt;
    end
  end

endmodule

// File: rtl/rr_request_source.sv
// Requester-side agent for the round-robin arbiter: per-requester job
// queues drive request, grants retire jobs, and the grant protocol,
// wait latency and starvation are monitored.
module rr_request_source
  import rr_arb_pkg::*;
#(
  parameter int nReq         = rr_arb_pkg::N_REQ,  // must match N_REQ
  parameter int CNT_W        = rr_arb_pkg::CNT_W,
  parameter int WAIT_W       = rr_arb_pkg::WAIT_W,
  parameter int STARVE_LIMIT = 2 * nReq
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           trigger,
  input  logic                           load_valid,
  input  logic [$clog2(nReq)-1:0]        load_idx,
  input  logic [CNT_W-1:0]               load_count,
  input  logic [nReq-1:0]                grant,
  output logic [nReq-1:0]                request,
  output logic [CNT_W+$clog2(nReq)-1:0]  pending_total,
  output logic [31:0]                    grant_total,
  output logic                           done,
  output logic [WAIT_W-1:0]              max_wait,
  output logic                           starve,
  output logic                           error
);

  localparam int IDX_W = $clog2(nReq);
  localparam int SUM_W = CNT_W + IDX_W;

  logic [CNT_W-1:0]  pend_nxt_s [nReq];
  logic [WAIT_W-1:0] wait_nxt_s [nReq];
  logic [nReq-1:0]   accept_s;
  logic              legal_s;
  logic              load_oob_s;
  logic              any_accept_s;
  logic [31:0]       load_idx_ext_s;
  logic [SUM_W-1:0]  total_nxt_s;
  logic [WAIT_W-1:0] wait_max_s;
  logic              starve_hit_s;

  logic [SUM_W-1:0]  pending_total_r;
  logic [31:0]       grant_total_r;
  logic              done_r;
  logic [WAIT_W-1:0] max_wait_r;
  logic              starve_r;
  logic              error_r;

  // Grant legality and load range check; an illegal grant retires nothing.
  always_comb begin
    load_idx_ext_s = 32'(load_idx);
    load_oob_s     = load_valid & (load_idx_ext_s >= 32'(nReq));
    legal_s        = onehot0(req_vec_t'(grant)) &
                     ((grant & ~request) == {nReq{1'b0}});
    if (legal_s) begin
      accept_s = grant & request;
    end else begin
      accept_s = {nReq{1'b0}};
    end
    any_accept_s = |accept_s;
  end

  for (genvar i = 0; i < nReq; i++) begin : g_slot
    rr_req_slot #(
      .CNT_W  (CNT_W),
      .WAIT_W (WAIT_W)
    ) u_slot (
      .clock      (clock),
      .reset      (reset),
      .trigger    (trigger),
      .load_en    (load_valid & ~load_oob_s & (load_idx == IDX_W'(i))),
      .load_count (load_count),
      .grant_bit  (grant[i]),
      .accept     (accept_s[i]),
      .request    (request[i]),
      .pend_nxt   (pend_nxt_s[i]),
      .wait_nxt   (wait_nxt_s[i])
    );
  end

  // Pending-total adder, max-wait reduction and starvation detect over next-state slot values.
  always_comb begin
    total_nxt_s  = {SUM_W{1'b0}};
    wait_max_s   = max_wait_r;
    starve_hit_s = 1'b0;
    for (int i = 0; i < nReq; i++) begin
      total_nxt_s = total_nxt_s + SUM_W'(pend_nxt_s[i]);
      if (wait_nxt_s[i] > wait_max_s) begin
        wait_max_s = wait_nxt_s[i];
      end else begin
        wait_max_s = wait_max_s;
      end
      if (32'(wait_nxt_s[i]) >= 32'(STARVE_LIMIT)) begin
        starve_hit_s = 1'b1;
      end else begin
        starve_hit_s = starve_hit_s;
      end
    end
  end

  // Registered status outputs; error and starve are sticky until reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_total_r <= {SUM_W{1'b0}};
      grant_total_r   <= 32'd0;
      done_r          <= 1'b0;
      max_wait_r      <= {WAIT_W{1'b0}};
      starve_r        <= 1'b0;
      error_r         <= 1'b0;
    end else begin
      pending_total_r <= total_nxt_s;
      grant_total_r   <= grant_total_r + 32'(any_accept_s);
      done_r          <= any_accept_s & (pending_total_r != {SUM_W{1'b0}}) &
                         (total_nxt_s == {SUM_W{1'b0}});
      max_wait_r      <= wait_max_s;
      starve_r        <= starve_r | starve_hit_s;
      error_r         <= error_r | ~legal_s | load_oob_s;
    end
  end

  assign pending_total = pending_total_r;
  assign grant_total   = grant_total_r;
  assign done          = done_r;
  assign max_wait      = max_wait_r;
  assign starve        = starve_r;
  assign error         = error_r;

endmodule

// File: tb/tb_rr_request_source.sv
// Directed bench for rr_request_source with a behavioural round-robin
// arbiter that can be swapped for a forced grant vector.
module tb_rr_request_source;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        trigger = 1'b0;
  logic        load_valid = 1'b0;
  logic [3:0]  load_idx = 4'd0;
  logic [7:0]  load_count = 8'd0;
  logic [15:0] grant;
  logic [15:0] request;
  logic [11:0] pending_total;
  logic [31:0] grant_total;
  logic        done;
  logic [15:0] max_wait;
  logic        starve;
  logic        error;

  logic        arb_en = 1'b0;
  logic [15:0] force_grant = 16'h0000;
  logic [15:0] arb_grant;
  logic [3:0]  arb_idx;
  logic [3:0]  ptr;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  rr_request_source dut (
    .clock         (clock),
    .reset         (reset),
    .trigger       (trigger),
    .load_valid    (load_valid),
    .load_idx      (load_idx),
    .load_count    (load_count),
    .grant         (grant),
    .request       (request),
    .pending_total (pending_total),
    .grant_total   (grant_total),
    .done          (done),
    .max_wait      (max_wait),
    .starve        (starve),
    .error         (error)
  );

  // Round-robin arbiter model: first requester after the last granted one.
  always_comb begin
    int j;
    logic found;
    arb_grant = 16'h0000;
    arb_idx   = 4'd0;
    found     = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      j = (int'(ptr) + k) % 16;
      if (!found && request[j]) begin
        arb_grant[j] = 1'b1;
        arb_idx      = 4'(j);
        found        = 1'b1;
      end
    end
  end

  assign grant = arb_en ? arb_grant : force_grant;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ptr <= 4'd15;
    else if (arb_en && arb_grant != 16'h0000) ptr <= arb_idx;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    trigger = 1'b0;
    load_valid = 1'b0;
    arb_en = 1'b0;
    force_grant = 16'h0000;
    step();
    reset = 1'b1;
  endtask

  task automatic load(input logic [3:0] idx, input logic [7:0] cnt);
    load_valid = 1'b1;
    load_idx = idx;
    load_count = cnt;
    step();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    total++;
    if ({request, pending_total, grant_total, done, max_wait, starve, error} !== 80'd0) begin
      bad++;
      $display("FAIL reset_state: got req=%h pt=%0d gt=%0d done=%b mw=%0d st=%b err=%b exp all 0",
               request, pending_total, grant_total, done, max_wait, starve, error);
    end
    reset = 1'b1;
  endtask

  task automatic test_two_jobs();
    load(4'd3, 8'd1);
    load(4'd7, 8'd1);
    total++;
    if (pending_total !== 12'd2) begin bad++; $display("FAIL two_load_total: got %0d exp 2", pending_total); end
    arb_en = 1'b1;
    trigger = 1'b1;
    #1;
    total++;
    if (request !== 16'h0088) begin bad++; $display("FAIL two_request: got %h exp 0088", request); end
    step();
    total++;
    if (pending_total !== 12'd1 || done !== 1'b0 || grant_total !== 32'd1) begin
      bad++; $display("FAIL two_first: got pt=%0d done=%b gt=%0d exp pt=1 done=0 gt=1", pending_total, done, grant_total);
    end
    step();
    total++;
    if (pending_total !== 12'd0 || done !== 1'b1 || grant_total !== 32'd2) begin
      bad++; $display("FAIL two_second: got pt=%0d done=%b gt=%0d exp pt=0 done=1 gt=2", pending_total, done, grant_total);
    end
    step();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL two_done_once: got done=%b exp 0", done); end
  endtask

  task automatic test_all_loaded();
    int dones;
    trigger = 1'b0;
    for (int i = 0; i < 16; i++) load(4'(i), 8'd4);
    total++;
    if (pending_total !== 12'd64) begin bad++; $display("FAIL all_load_total: got %0d exp 64", pending_total); end
    trigger = 1'b1;
    dones = 0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (done === 1'b1) dones++;
      if (pending_total === 12'd0) break;
    end
    total++;
    if (pending_total !== 12'd0) begin bad++; $display("FAIL all_drain_timeout: got pt=%0d exp 0", pending_total); end
    total++;
    if (grant_total !== 32'd66) begin bad++; $display("FAIL all_grants: got %0d exp 66", grant_total); end
    total++;
    if (max_wait !== 16'd15) begin bad++; $display("FAIL all_max_wait: got %0d exp 15", max_wait); end
    total++;
    if (starve !== 1'b0 || error !== 1'b0) begin
      bad++; $display("FAIL all_flags: got starve=%b error=%b exp 0 0", starve, error);
    end
    total++;
    if (dones !== 1) begin bad++; $display("FAIL all_done_count: got %0d exp 1", dones); end
  endtask

  task automatic test_illegal_grant();
    do_reset();
    load(4'd0, 8'd2);
    load(4'd1, 8'd2);
    trigger = 1'b1;
    force_grant = 16'h0003;
    #1;
    total++;
    if (error !== 1'b0) begin bad++; $display("FAIL illegal_pre: got error=%b exp 0", error); end
    step();
    total++;
    if (error !== 1'b1 || pending_total !== 12'd4 || grant_total !== 32'd0) begin
      bad++; $display("FAIL illegal_hit: got err=%b pt=%0d gt=%0d exp 1 4 0", error, pending_total, grant_total);
    end
    force_grant = 16'h0000;
    step();
    step();
    total++;
    if (error !== 1'b1 || pending_total !== 12'd4 || request !== 16'h0003) begin
      bad++; $display("FAIL illegal_sticky: got err=%b pt=%0d req=%h exp 1 4 0003", error, pending_total, request);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    load(4'd5, 8'd255);
    load(4'd5, 8'd10);
    total++;
    if (pending_total !== 12'd255) begin bad++; $display("FAIL sat_load: got %0d exp 255", pending_total); end
    trigger = 1'b1;
    force_grant = 16'h0020;
    load(4'd5, 8'd5);
    total++;
    if (pending_total !== 12'd255 || grant_total !== 32'd1) begin
      bad++; $display("FAIL sat_load_grant: got pt=%0d gt=%0d exp 255 1", pending_total, grant_total);
    end
    step();
    total++;
    if (pending_total !== 12'd254) begin bad++; $display("FAIL sat_decrement: got %0d exp 254", pending_total); end
    force_grant = 16'h0000;
    trigger = 1'b0;
    load(4'd2, 8'd3);
    trigger = 1'b1;
    force_grant = 16'h0004;
    load(4'd2, 8'd2);
    total++;
    if (pending_total !== 12'd258 || grant_total !== 32'd3 || error !== 1'b0) begin
      bad++; $display("FAIL load_and_grant: got pt=%0d gt=%0d err=%b exp 258 3 0", pending_total, grant_total, error);
    end
  endtask

  task automatic test_starve();
    do_reset();
    load(4'd0, 8'd1);
    trigger = 1'b1;
    for (int c = 0; c < 31; c++) step();
    total++;
    if (max_wait !== 16'd31 || starve !== 1'b0) begin
      bad++; $display("FAIL starve_edge: got mw=%0d st=%b exp 31 0", max_wait, starve);
    end
    step();
    total++;
    if (max_wait !== 16'd32 || starve !== 1'b1) begin
      bad++; $display("FAIL starve_hit: got mw=%0d st=%b exp 32 1", max_wait, starve);
    end
    trigger = 1'b0;
    #1;
    total++;
    if (request !== 16'h0000) begin bad++; $display("FAIL trigger_drop: got req=%h exp 0000", request); end
    step();
    total++;
    if (pending_total !== 12'd1 || starve !== 1'b1) begin
      bad++; $display("FAIL trigger_retain: got pt=%0d st=%b exp 1 1", pending_total, starve);
    end
  endtask

  task automatic test_mid_reset();
    trigger = 1'b1;
    #1;
    total++;
    if (request !== 16'h0001) begin bad++; $display("FAIL mid_pre_req: got %h exp 0001", request); end
    #1;
    reset = 1'b0;
    #1;
    total++;
    if ({request, pending_total, grant_total, done, max_wait, starve, error} !== 80'd0) begin
      bad++;
      $display("FAIL mid_reset: got req=%h pt=%0d gt=%0d done=%b mw=%0d st=%b err=%b exp all 0",
               request, pending_total, grant_total, done, max_wait, starve, error);
    end
    step();
    reset = 1'b1;
    step();
    total++;
    if (request !== 16'h0000 || pending_total !== 12'd0) begin
      bad++; $display("FAIL mid_after: got req=%h pt=%0d exp 0000 0", request, pending_total);
    end
  endtask

  initial begin
    test_reset();
    test_two_jobs();
    test_all_loaded();
    test_illegal_grant();
    test_saturate();
    test_starve();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
